// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared definitions for the HD44780 reader/writer pair: the reader FSM state
// encoding, the status-byte bit positions and the default bus timing in
// clk cycles.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EN_HI = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } lcdState_t;

  // Status byte layout while RS=0, RW=1
  localparam int BF_BIT = 7;
  localparam int AC_MSB = 6;
  localparam int AC_LSB = 0;

  localparam int DEF_SETUP_CYC   = 2;
  localparam int DEF_EN_HIGH_CYC = 16;
  localparam int DEF_HOLD_CYC    = 2;
  localparam int DEF_TIMEOUT_CYC = 100000;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cntWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_busy_reader_if.sv
// lcd_busy_reader_if
// Host request/response signals plus the LCD-side read bus of the busy reader.
//   master : host / LCD environment (drives req, rs_sel, poll, lcd_data_in)
//   slave  : lcd_busy_reader (drives strobes, status and read results)
interface lcd_busy_reader_if;
  import lcd_pkg::*;

  logic                req;
  logic                rs_sel;
  logic                poll;
  logic [7:0]          lcd_data_in;
  logic                lcd_en;
  logic                lcd_rw;
  logic                lcd_rs;
  logic                rd_active;
  logic                ready;
  logic                rd_valid;
  logic [7:0]          rd_data;
  logic                busy_flag;
  logic [AC_MSB:AC_LSB] addr_counter;
  logic                timeout;

  modport master (
    output req, rs_sel, poll, lcd_data_in,
    input  lcd_en, lcd_rw, lcd_rs, rd_active, ready, rd_valid,
           rd_data, busy_flag, addr_counter, timeout
  );

  modport slave (
    input  req, rs_sel, poll, lcd_data_in,
    output lcd_en, lcd_rw, lcd_rs, rd_active, ready, rd_valid,
           rd_data, busy_flag, addr_counter, timeout
  );

endinterface

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer
// Loadable down-counter timing one bus phase. Load with (cycles-1); done is
// high in the last cycle of the phase (count == 0).
//   clk, reset : clock, synchronous active-high reset
//   load       : load loadVal this edge (takes priority over counting)
//   loadVal    : phase length minus one
//   done       : terminal count reached
module lcd_phase_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_busy_reader.sv
// lcd_busy_reader
// Performs HD44780 read cycles (status or DDRAM) on request, optionally
// repeating status reads until the busy flag clears or a timeout expires.
//   clk, reset : clock, synchronous active-high reset
//   bus        : lcd_busy_reader_if.slave (host handshake + LCD read bus)
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | ready, waiting for req
// ST_SETUP | RS/RW stable, EN low (address setup)
// ST_EN_HI | EN high; bus sampled at end of last cycle
// ST_HOLD  | EN low, RS/RW held; decides poll again or finish
// ST_DONE  | rd_valid pulse, back to idle
module lcd_busy_reader
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int EN_HIGH_CYC = DEF_EN_HIGH_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic               clk,
  input logic               reset,
  lcd_busy_reader_if.slave  bus
);

  // All phase lengths must be at least 1 cycle.
  localparam int PW = cntWidth(maxOf3(SETUP_CYC, EN_HIGH_CYC, HOLD_CYC));
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PW-1:0] SETUP_LD = PW'(SETUP_CYC - 1);
  localparam logic [PW-1:0] EN_LD    = PW'(EN_HIGH_CYC - 1);
  localparam logic [PW-1:0] HOLD_LD  = PW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC);

  lcdState_t            state, stateNext;
  logic                 timerLoad;
  logic [PW-1:0]        timerLoadVal;
  logic                 timerDone;
  logic                 accept;
  logic                 sampleBus;
  logic                 setTimeout;
  logic                 keepPolling;

  logic                 rsLat;
  logic                 pollLat;
  logic [TW-1:0]        toCnt;
  logic [7:0]           rdData;
  logic                 busyFlag;
  logic [AC_MSB:AC_LSB] addrCnt;
  logic                 timeoutFlag;

  lcd_phase_timer #(.WIDTH(PW)) uTimer (
    .clk     (clk),
    .reset   (reset),
    .load    (timerLoad),
    .loadVal (timerLoadVal),
    .done    (timerDone)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    timerLoad    = 1'b0;
    timerLoadVal = '0;
    accept       = 1'b0;
    sampleBus    = 1'b0;
    setTimeout   = 1'b0;
    // Polling only makes sense for status reads; rdData holds the last status.
    keepPolling  = pollLat && !rsLat && rdData[BF_BIT];

    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          accept       = 1'b1;
          timerLoad    = 1'b1;
          timerLoadVal = SETUP_LD;
          stateNext    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (timerDone) begin
          timerLoad    = 1'b1;
          timerLoadVal = EN_LD;
          stateNext    = ST_EN_HI;
        end
      end
      ST_EN_HI: begin
        if (timerDone) begin
          sampleBus    = 1'b1;
          timerLoad    = 1'b1;
          timerLoadVal = HOLD_LD;
          stateNext    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (timerDone) begin
          if (keepPolling && (toCnt < TO_MAX)) begin
            timerLoad    = 1'b1;
            timerLoadVal = SETUP_LD;
            stateNext    = ST_SETUP;
          end else begin
            setTimeout = keepPolling;
            stateNext  = ST_DONE;
          end
        end
      end
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsLat       <= 1'b0;
      pollLat     <= 1'b0;
      toCnt       <= '0;
      rdData      <= '0;
      busyFlag    <= 1'b0;
      addrCnt     <= '0;
      timeoutFlag <= 1'b0;
    end else begin
      if (accept) begin
        rsLat       <= bus.rs_sel;
        pollLat     <= bus.poll;
        toCnt       <= '0;
        timeoutFlag <= 1'b0;
      end else if ((state != ST_IDLE) && (toCnt != TO_MAX)) begin
        toCnt <= toCnt + TW'(1);
      end

      if (sampleBus) begin
        rdData <= bus.lcd_data_in;
        if (!rsLat) begin
          busyFlag <= bus.lcd_data_in[BF_BIT];
          addrCnt  <= bus.lcd_data_in[AC_MSB:AC_LSB];
        end
      end

      if (setTimeout) timeoutFlag <= 1'b1;
    end
  end

  assign bus.lcd_en       = (state == ST_EN_HI);
  assign bus.lcd_rw       = (state != ST_IDLE);
  assign bus.rd_active    = (state != ST_IDLE);
  assign bus.lcd_rs       = (state != ST_IDLE) && rsLat;
  assign bus.ready        = (state == ST_IDLE);
  assign bus.rd_valid     = (state == ST_DONE);
  assign bus.rd_data      = rdData;
  assign bus.busy_flag    = busyFlag;
  assign bus.addr_counter = addrCnt;
  assign bus.timeout      = timeoutFlag;

endmodule

// File: tb/tb_lcd_busy_reader.sv
// tb_lcd_busy_reader
// Directed bench for lcd_busy_reader with TIMEOUT_CYC=100.
module tb_lcd_busy_reader;

  logic clk = 1'b0;
  logic reset;
  int   passCnt  = 0;
  int   totalCnt = 0;

  lcd_busy_reader_if busIf ();

  lcd_busy_reader #(.TIMEOUT_CYC(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) begin
      passCnt++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it until rd_valid (bounded). Pulses
  // 1..nBusy see busyVal on the bus, later pulses see finalVal.
  task automatic runRead(input logic rs, input logic pl, input logic [7:0] busyVal,
                         input int nBusy, input logic [7:0] finalVal,
                         output int lat, output int enCyc, output int enPulses,
                         output int rsBad, output int rwBad);
    logic prevEn;
    busIf.req         = 1'b1;
    busIf.rs_sel      = rs;
    busIf.poll        = pl;
    busIf.lcd_data_in = (nBusy > 0) ? busyVal : finalVal;
    step();
    busIf.req = 1'b0;
    lat = 1; enCyc = 0; enPulses = 0; rsBad = 0; rwBad = 0; prevEn = 1'b0;
    while (lat < 400) begin
      if (busIf.lcd_en) enCyc++;
      if (busIf.lcd_en && !prevEn) enPulses++;
      prevEn = busIf.lcd_en;
      if (busIf.lcd_rs !== rs) rsBad++;
      if (busIf.lcd_rw !== 1'b1) rwBad++;
      busIf.lcd_data_in = (enPulses <= nBusy && nBusy > 0) ? busyVal : finalVal;
      if (busIf.rd_valid) break;
      step();
      lat++;
    end
  endtask

  task automatic afterRead(input string tag);
    step();
    check({tag, "_ready_after"}, 32'(busIf.ready), 1);
    check({tag, "_rw_after"}, 32'(busIf.lcd_rw), 0);
    check({tag, "_valid_after"}, 32'(busIf.rd_valid), 0);
  endtask

  initial begin
    int lat, enCyc, enPulses, rsBad, rwBad, seenValid, seenEn;

    reset = 1'b1;
    busIf.req = 1'b0; busIf.rs_sel = 1'b0; busIf.poll = 1'b0; busIf.lcd_data_in = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_lcd_en", 32'(busIf.lcd_en), 0);
    check("rst_lcd_rw", 32'(busIf.lcd_rw), 0);
    check("rst_lcd_rs", 32'(busIf.lcd_rs), 0);
    check("rst_rd_active", 32'(busIf.rd_active), 0);
    check("rst_ready", 32'(busIf.ready), 1);
    check("rst_rd_valid", 32'(busIf.rd_valid), 0);
    check("rst_rd_data", 32'(busIf.rd_data), 0);
    check("rst_busy", 32'(busIf.busy_flag), 0);
    check("rst_addr", 32'(busIf.addr_counter), 0);
    check("rst_timeout", 32'(busIf.timeout), 0);

    // Single status read, bus 0x25
    runRead(1'b0, 1'b0, 8'h25, 0, 8'h25, lat, enCyc, enPulses, rsBad, rwBad);
    check("st_latency", lat, 21);
    check("st_en_cycles", enCyc, 16);
    check("st_en_pulses", enPulses, 1);
    check("st_rw_held", rwBad, 0);
    check("st_rs_low", rsBad, 0);
    check("st_busy", 32'(busIf.busy_flag), 0);
    check("st_addr", 32'(busIf.addr_counter), 32'h25);
    check("st_data", 32'(busIf.rd_data), 32'h25);
    check("st_timeout", 32'(busIf.timeout), 0);
    afterRead("st");

    // DDRAM read, bus 0x41: status fields untouched
    runRead(1'b1, 1'b0, 8'h41, 0, 8'h41, lat, enCyc, enPulses, rsBad, rwBad);
    check("dd_latency", lat, 21);
    check("dd_rs_high", rsBad, 0);
    check("dd_data", 32'(busIf.rd_data), 32'h41);
    check("dd_busy", 32'(busIf.busy_flag), 0);
    check("dd_addr", 32'(busIf.addr_counter), 32'h25);
    afterRead("dd");

    // Poll: three busy strobes then 0x10
    runRead(1'b0, 1'b1, 8'h80, 3, 8'h10, lat, enCyc, enPulses, rsBad, rwBad);
    check("poll_pulses", enPulses, 4);
    check("poll_latency", lat, 81);
    check("poll_en_cycles", enCyc, 64);
    check("poll_rw_held", rwBad, 0);
    check("poll_busy", 32'(busIf.busy_flag), 0);
    check("poll_addr", 32'(busIf.addr_counter), 32'h10);
    check("poll_timeout", 32'(busIf.timeout), 0);
    afterRead("poll");

    // Poll with bus stuck 0xFF: abandoned after the 6th strobe
    runRead(1'b0, 1'b1, 8'hFF, 1000, 8'hFF, lat, enCyc, enPulses, rsBad, rwBad);
    check("to_pulses", enPulses, 6);
    check("to_latency", lat, 121);
    check("to_timeout", 32'(busIf.timeout), 1);
    check("to_busy", 32'(busIf.busy_flag), 1);
    check("to_addr", 32'(busIf.addr_counter), 32'h7F);
    afterRead("to");
    check("to_timeout_held", 32'(busIf.timeout), 1);

    // Next accept clears timeout
    runRead(1'b0, 1'b0, 8'h25, 0, 8'h25, lat, enCyc, enPulses, rsBad, rwBad);
    check("clr_timeout", 32'(busIf.timeout), 0);
    check("clr_latency", lat, 21);
    check("clr_busy", 32'(busIf.busy_flag), 0);
    afterRead("clr");

    // DDRAM read with poll=1 and bit7 set: poll ignored
    runRead(1'b1, 1'b1, 8'hC1, 0, 8'hC1, lat, enCyc, enPulses, rsBad, rwBad);
    check("ddp_pulses", enPulses, 1);
    check("ddp_latency", lat, 21);
    check("ddp_data", 32'(busIf.rd_data), 32'hC1);
    check("ddp_busy", 32'(busIf.busy_flag), 0);
    check("ddp_addr", 32'(busIf.addr_counter), 32'h25);
    check("ddp_timeout", 32'(busIf.timeout), 0);
    afterRead("ddp");

    // Reset in the 5th EN_HI cycle; a req issued mid-read must not be queued
    busIf.req = 1'b1; busIf.rs_sel = 1'b0; busIf.poll = 1'b0; busIf.lcd_data_in = 8'h25;
    step();                       // cycle 1 (SETUP)
    busIf.req = 1'b0;
    step();                       // cycle 2
    busIf.req = 1'b1;
    step();                       // cycle 3, first EN_HI
    busIf.req = 1'b0;
    check("rr_en_first", 32'(busIf.lcd_en), 1);
    repeat (4) step();            // cycle 7, fifth EN_HI
    check("rr_en_fifth", 32'(busIf.lcd_en), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rr_en", 32'(busIf.lcd_en), 0);
    check("rr_rw", 32'(busIf.lcd_rw), 0);
    check("rr_ready", 32'(busIf.ready), 1);
    check("rr_valid", 32'(busIf.rd_valid), 0);
    check("rr_active", 32'(busIf.rd_active), 0);
    check("rr_rd_data", 32'(busIf.rd_data), 0);
    seenValid = 0; seenEn = 0;
    for (int i = 0; i < 40; i++) begin
      if (busIf.rd_valid) seenValid++;
      if (busIf.lcd_en) seenEn++;
      step();
    end
    check("rr_no_valid", seenValid, 0);
    check("rr_no_requeue", seenEn, 0);
    check("rr_idle_ready", 32'(busIf.ready), 1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
